// File: rtl/sort_arb_pkg.sv
// Shared types and default sizing for the sorting-network arbiter.
// The typedefs describe the default configuration; modules re-derive widths from their parameters.
package sort_arb_pkg;

    localparam int NUMBER_WIDTH_DEF   = 10;
    localparam int NUMBERS_AMOUNT_DEF = 10;
    localparam int REQ_CNT_DEF        = 4;
    localparam int MAX_INFLIGHT_DEF   = 8;

    typedef logic [NUMBER_WIDTH_DEF-1:0]        number_t;
    typedef number_t [NUMBERS_AMOUNT_DEF-1:0]   vector_t;
    typedef logic [$clog2(REQ_CNT_DEF)-1:0]     req_id_t;

    // Round-robin candidate index: 'offset' positions after 'base', modulo n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/sort_tag_fifo.sv
// Requester-ID FIFO tracking vectors in flight through the sorting network.
// Head entry is readable combinationally so a returning result can be steered in the same cycle.
module sort_tag_fifo
    import sort_arb_pkg::*;
#(
    parameter int DEPTH = MAX_INFLIGHT_DEF,
    parameter int WIDTH = $bits(req_id_t)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointers are PW bits wide, so wrapping modulo DEPTH is implicit.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sort_arbiter.sv
// Round-robin front end sharing one fixed-latency sorting network among several requesters.
// Results are steered back to their originator using a FIFO of requester IDs.
module sort_arbiter
    import sort_arb_pkg::*;
#(
    parameter int NUMBER_WIDTH   = NUMBER_WIDTH_DEF,
    parameter int NUMBERS_AMOUNT = NUMBERS_AMOUNT_DEF,
    parameter int REQ_CNT        = REQ_CNT_DEF,
    parameter int MAX_INFLIGHT   = MAX_INFLIGHT_DEF
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic [REQ_CNT-1:0][NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] req_data_i,
    input  logic [REQ_CNT-1:0]                                    req_valid_i,
    output logic [REQ_CNT-1:0]                                    req_ready_o,
    output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]           sn_data_o,
    output logic                                                  sn_valid_o,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]           sn_data_i,
    input  logic                                                  sn_valid_i,
    output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]           resp_data_o,
    output logic [REQ_CNT-1:0]                                    resp_valid_o,
    output logic                                                  err_o,
    output logic [$clog2(MAX_INFLIGHT):0]                         inflight_o
);

    localparam int ID_W = $clog2(REQ_CNT);
    localparam int CW   = $clog2(MAX_INFLIGHT) + 1;

    typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vec_t;

    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    cand, win_id, head_tag;
    logic               win_found, grant_ok, accept, pop;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;
    vec_t               sn_data_q, sn_data_d;
    vec_t               resp_data_q, resp_data_d;
    logic               sn_valid_q, sn_valid_d;
    logic [REQ_CNT-1:0] resp_valid_q, resp_valid_d;
    logic               err_q, err_d;

    // Walk requesters starting just after the last winner; the first valid one wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = last_q;
        cand      = last_q;
        for (int off = 1; off <= REQ_CNT; off++) begin
            cand = ID_W'(rr_index(int'(last_q), off, REQ_CNT));
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign grant_ok = win_found && !fifo_full && !rst_i;
    assign accept   = grant_ok;
    assign pop      = sn_valid_i && !fifo_empty;

    for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_ready
        assign req_ready_o[gi] = grant_ok && (win_id == ID_W'(gi));
    end

    sort_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (win_id),
        .pop_i       (pop),
        .pop_data_o  (head_tag),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        last_d       = last_q;
        sn_valid_d   = accept;
        sn_data_d    = sn_data_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        err_d        = err_q;
        if (accept) begin
            last_d    = win_id;
            sn_data_d = req_data_i[win_id];
        end
        if (pop) begin
            resp_valid_d = REQ_CNT'(1) << head_tag;
            resp_data_d  = sn_data_i;
        end
        // A result with no matching tag is dropped and flagged until reset.
        if (sn_valid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q       <= ID_W'(REQ_CNT - 1);
            sn_valid_q   <= 1'b0;
            sn_data_q    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            last_q       <= last_d;
            sn_valid_q   <= sn_valid_d;
            sn_data_q    <= sn_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
        end
    end

    assign sn_valid_o   = sn_valid_q;
    assign sn_data_o    = sn_data_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign err_o        = err_q;
    assign inflight_o   = fifo_count;

endmodule

// File: tb/tb_sort_arbiter.sv
// Bench for sort_arbiter: a fixed-latency sorting network model, a queue-based reference
// model checked every cycle, and directed scenarios with hand-computed expectations.
module tb_sort_arbiter;

    localparam int NW = 10;
    localparam int NA = 10;
    localparam int RC = 4;
    localparam int MI = 8;
    localparam int CW = $clog2(MI) + 1;

    typedef logic [NA-1:0][NW-1:0] vec_t;

    logic                           clk_i = 1'b0;
    logic                           rst_i = 1'b1;
    logic [RC-1:0][NA-1:0][NW-1:0]  req_data_i = '0;
    logic [RC-1:0]                  req_valid_i = '0;
    logic [RC-1:0]                  req_ready_o;
    vec_t                           sn_data_o;
    logic                           sn_valid_o;
    vec_t                           sn_data_i;
    logic                           sn_valid_i;
    vec_t                           resp_data_o;
    logic [RC-1:0]                  resp_valid_o;
    logic                           err_o;
    logic [CW-1:0]                  inflight_o;

    int n_cmp = 0;
    int n_bad = 0;

    sort_arbiter #(
        .NUMBER_WIDTH   (NW),
        .NUMBERS_AMOUNT (NA),
        .REQ_CNT        (RC),
        .MAX_INFLIGHT   (MI)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_data_i   (req_data_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .sn_data_o    (sn_data_o),
        .sn_valid_o   (sn_valid_o),
        .sn_data_i    (sn_data_i),
        .sn_valid_i   (sn_valid_i),
        .resp_data_o  (resp_data_o),
        .resp_valid_o (resp_valid_o),
        .err_o        (err_o),
        .inflight_o   (inflight_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h required %0h", nm, $time, act, exp);
        end
    endtask

    // Network model: index NA-1 ends up holding the smallest number.
    function automatic vec_t net_sort(input vec_t v);
        int   a [NA];
        int   t;
        vec_t r;
        for (int i = 0; i < NA; i++) a[i] = int'(v[i]);
        for (int i = 0; i < NA; i++)
            for (int j = 0; j < NA - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int j = 0; j < NA; j++) r[NA-1-j] = NW'(a[j]);
        return r;
    endfunction

    int   lat   = 5;
    logic inj_v = 1'b0;
    vec_t inj_d = '0;
    logic pipe_v [0:31] = '{default: 1'b0};
    vec_t pipe_d [0:31] = '{default: '0};

    always @(posedge clk_i) begin
        pipe_v[0] <= sn_valid_o;
        pipe_d[0] <= net_sort(sn_data_o);
        for (int i = 1; i < 32; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    always_comb begin
        sn_valid_i = pipe_v[lat-1] | inj_v;
        sn_data_i  = inj_v ? inj_d : pipe_d[lat-1];
    end

    // Reference model: state describes what the DUT should show after the next rising edge.
    int            m_last = RC - 1;
    int            m_tags [$];
    logic          m_snv = 1'b0;
    vec_t          m_snd = '0;
    logic [RC-1:0] m_rv  = '0;
    vec_t          m_rd  = '0;
    logic          m_err = 1'b0;

    always @(negedge clk_i) begin
        logic [RC-1:0] exp_rdy;
        int            w;
        int            c;
        int            t;
        if (rst_i) begin
            m_last = RC - 1;
            m_tags.delete();
            m_snv = 1'b0; m_snd = '0; m_rv = '0; m_rd = '0; m_err = 1'b0;
        end
        exp_rdy = '0;
        w = -1;
        if (!rst_i && m_tags.size() < MI) begin
            for (int o = 1; o <= RC; o++) begin
                c = (m_last + o) % RC;
                if (w < 0 && req_valid_i[c]) w = c;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("ready", req_ready_o, exp_rdy);
        chk("sn_valid", sn_valid_o, m_snv);
        chk("sn_data", sn_data_o, m_snd);
        chk("resp_valid", resp_valid_o, m_rv);
        chk("resp_data", resp_data_o, m_rd);
        chk("err", err_o, m_err);
        chk("inflight", inflight_o, m_tags.size());
        if (resp_valid_o != '0)
            $display("resp owner=%b data=%h", resp_valid_o, resp_data_o);
        if (!rst_i) begin
            m_rv = '0;
            if (sn_valid_i) begin
                if (m_tags.size() > 0) begin
                    t    = m_tags.pop_front();
                    m_rv = RC'(1) << t;
                    m_rd = sn_data_i;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (w >= 0) begin
                m_snv  = 1'b1;
                m_snd  = req_data_i[w];
                m_tags.push_back(w);
                m_last = w;
            end else begin
                m_snv = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        inj_v       = 1'b0;
        repeat (2) step();
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        vec_t          v;
        vec_t          e;
        int            acc;
        int            guard;
        logic [RC-1:0] seq [$];

        for (int k = 0; k < RC; k++)
            for (int i = 0; i < NA; i++)
                req_data_i[k][i] = NW'(100 * k + 7 * i + 1);

        // Reset values, with every requester asking.
        req_valid_i = '1;
        #2;
        chk("rst_ready", req_ready_o, 4'b0000);
        chk("rst_sn_valid", sn_valid_o, 1'b0);
        chk("rst_sn_data", sn_data_o, '0);
        chk("rst_resp_valid", resp_valid_o, 4'b0000);
        chk("rst_resp_data", resp_data_o, '0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_inflight", inflight_o, 0);
        req_valid_i = '0;
        repeat (2) step();
        rst_i = 1'b0;

        // Single request from requester 2, network latency 5.
        lat = 5;
        step();
        for (int i = 0; i < NA; i++) v[i] = NW'(i);
        req_data_i[2] = v;
        req_valid_i   = 4'b0100;
        #1;
        chk("single_ready", req_ready_o, 4'b0100);
        step();
        req_valid_i = '0;
        chk("single_sn_valid", sn_valid_o, 1'b1);
        chk("single_sn_data", sn_data_o, v);
        chk("single_inflight", inflight_o, 1);
        repeat (5) step();
        chk("single_resp_early", resp_valid_o, 4'b0000);
        step();
        e = {10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9};
        chk("single_resp_valid", resp_valid_o, 4'b0100);
        chk("single_resp_data", resp_data_o, e);
        chk("single_inflight_after", inflight_o, 0);

        // Fairness: everyone asks for 8 cycles.
        do_reset();
        lat = 3;
        seq.delete();
        req_valid_i = '1;
        for (int c = 0; c < 30; c++) begin
            if (c == 8) req_valid_i = '0;
            #1;
            if (c < 8) chk("fair_ready", req_ready_o, RC'(1) << (c % 4));
            if (resp_valid_o != '0) seq.push_back(resp_valid_o);
            step();
        end
        chk("fair_resp_count", seq.size(), 8);
        for (int i = 0; i < seq.size(); i++)
            chk("fair_resp_owner", seq[i], RC'(1) << (i % 4));

        // Full: long network, everyone asking.
        do_reset();
        lat = 20;
        acc = 0;
        req_valid_i = '1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready_o != '0) acc++;
            step();
        end
        chk("full_accepts", acc, 8);
        #1;
        chk("full_ready", req_ready_o, 4'b0000);
        chk("full_inflight", inflight_o, 8);
        guard = 0;
        while (!sn_valid_i && guard < 30) begin
            step();
            guard++;
        end
        chk("full_return_seen", sn_valid_i, 1'b1);
        chk("full_ready_on_pop", req_ready_o, 4'b0000);
        step();
        chk("full_regrant", req_ready_o, 4'b0001);
        chk("full_inflight_pop", inflight_o, 7);
        req_valid_i = '0;
        repeat (40) step();

        // Simultaneous push and pop at occupancy 3, tags returned in order.
        do_reset();
        lat = 2;
        seq.delete();
        req_valid_i = 4'b1010;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) req_valid_i = '0;
            #1;
            if (c >= 4 && c < 12) begin
                chk("pp_inflight", inflight_o, 3);
                chk("pp_push_and_pop", {sn_valid_i, req_ready_o != '0}, 2'b11);
            end
            if (resp_valid_o != '0) seq.push_back(resp_valid_o);
            step();
        end
        chk("pp_resp_count", seq.size(), 12);
        for (int i = 0; i < seq.size(); i++)
            chk("pp_resp_owner", seq[i], (i % 2 == 0) ? 4'b0010 : 4'b1000);

        // Spurious result with nothing in flight.
        do_reset();
        step();
        inj_d = e;
        inj_v = 1'b1;
        step();
        inj_v = 1'b0;
        #1;
        chk("spur_resp_valid", resp_valid_o, 4'b0000);
        chk("spur_err", err_o, 1'b1);
        repeat (5) step();
        chk("spur_err_sticky", err_o, 1'b1);
        do_reset();
        #1;
        chk("spur_err_cleared", err_o, 1'b0);

        // Asynchronous reset with 5 vectors in flight.
        lat = 20;
        req_valid_i = '1;
        repeat (5) step();
        req_valid_i = '0;
        #1;
        chk("mid_inflight_before", inflight_o, 5);
        step();
        req_valid_i = '1;
        #1;
        rst_i = 1'b1;
        #1;
        chk("mid_ready", req_ready_o, 4'b0000);
        chk("mid_sn_valid", sn_valid_o, 1'b0);
        chk("mid_sn_data", sn_data_o, '0);
        chk("mid_resp_valid", resp_valid_o, 4'b0000);
        chk("mid_resp_data", resp_data_o, '0);
        chk("mid_err", err_o, 1'b0);
        chk("mid_inflight", inflight_o, 0);
        step();
        rst_i = 1'b0;
        #1;
        chk("mid_first_grant", req_ready_o, 4'b0001);
        req_valid_i = '0;
        repeat (30) step();
        chk("mid_stale_err", err_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
